dec_job_scheduler: RTL and testbench

- Job-level controller placed in front of the single axi_io decompression engine.
- Accepts decompression job descriptors from the host-side slave logic into a small queue, and launches them one at a time.
- For each job: drives the engine's address/length inputs, pulses start, and waits for done.
- Returns a completion record per job with ID, cycle count and timeout flag.

---
 rtl/dec_sched_pkg.sv | 34 +++
 rtl/dec_job_scheduler_fifo.sv | 68 ++++++
 rtl/dec_job_scheduler.sv | 186 ++++++++++++++++++
 tb/tb_dec_job_scheduler.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dec_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dec_sched_pkg
// Brief    : Shared types and constants for the decompression job scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package dec_sched_pkg;

   localparam int CYCLE_W     = 32;
   localparam logic [CYCLE_W-1:0] CYCLE_SAT = '1;
   localparam int DESC_ADDR_W = 64;
   localparam int DESC_ID_W   = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LAUNCH = 2'd1,
      RUN    = 2'd2,
      REPORT = 2'd3
   } sched_state_t;

   typedef struct packed {
      logic [DESC_ID_W-1:0]   id;
      logic [DESC_ADDR_W-1:0] src;
      logic [DESC_ADDR_W-1:0] des;
      logic [31:0]            comp_len;
      logic [31:0]            decomp_len;
   } sched_desc_t;

   function automatic logic [CYCLE_W-1:0] sat_inc(input logic [CYCLE_W-1:0] v);
      return (v == CYCLE_SAT) ? v : v + 1'b1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/dec_job_scheduler_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sched_desc_fifo
// Brief    : Synchronous first-word-fall-through FIFO of job descriptors.
// Revision : 1.0 - initial release
// ============================================================================
module sched_desc_fifo
   import dec_sched_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  sched_desc_t            push_data,
   input  logic                   pop,
   output sched_desc_t            head,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int c_ptr_w = $clog2(DEPTH);
   localparam logic [c_ptr_w:0] c_depth = (c_ptr_w + 1)'(DEPTH);

   sched_desc_t        r_mem [DEPTH];
   logic [c_ptr_w-1:0] r_wr_ptr;
   logic [c_ptr_w-1:0] r_rd_ptr;
   logic [c_ptr_w:0]   r_count;
   logic               w_wr;
   logic               w_rd;

   // A pop frees the head slot in the same cycle, so a full FIFO may still accept a write.
   assign w_wr  = push && (!full || pop);
   assign w_rd  = pop && !empty;
   assign full  = (r_count == c_depth);
   assign empty = (r_count == '0);
   assign count = r_count;
   assign head  = r_mem[r_rd_ptr];

   always_ff @(posedge clk) begin
      if (w_wr) begin
         r_mem[r_wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_wr) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_rd) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_wr, w_rd})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/dec_job_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : dec_job_scheduler
// Brief    : Queues decompression jobs and runs them one at a time on the engine.
// Options  : DEC_SCHED_TIMEOUT_EN enables the RUN-state watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module dec_job_scheduler
   import dec_sched_pkg::*;
#(
   parameter int          ADDR_W         = 64,
   parameter int          ID_W           = 8,
   parameter int          DEPTH          = 4,
   parameter logic [31:0] TIMEOUT_CYCLES = 32'd100000000
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   job_valid,
   output logic                   job_ready,
   input  logic [ID_W-1:0]        job_id,
   input  logic [ADDR_W-1:0]      job_src_addr,
   input  logic [ADDR_W-1:0]      job_des_addr,
   input  logic [31:0]            job_comp_len,
   input  logic [31:0]            job_decomp_len,
   output logic                   eng_start,
   output logic [ADDR_W-1:0]      eng_src_addr,
   output logic [ADDR_W-1:0]      eng_des_addr,
   output logic [31:0]            eng_comp_len,
   output logic [31:0]            eng_decomp_len,
   input  logic                   eng_idle,
   input  logic                   eng_done,
   output logic                   cpl_valid,
   input  logic                   cpl_ready,
   output logic [ID_W-1:0]        cpl_id,
   output logic [31:0]            cpl_cycles,
   output logic                   cpl_timeout,
   output logic                   busy,
   output logic [$clog2(DEPTH):0] queue_count
);

   sched_state_t       r_state;
   sched_state_t       w_state_nxt;
   logic               r_ready_en;
   logic               r_start;
   logic               r_armed;
   logic               r_timeout;
   logic [ID_W-1:0]    r_id;
   logic [CYCLE_W-1:0] r_cycles;
   logic [ADDR_W-1:0]  r_eng_src;
   logic [ADDR_W-1:0]  r_eng_des;
   logic [31:0]        r_eng_comp;
   logic [31:0]        r_eng_decomp;
   logic               w_full;
   logic               w_empty;
   logic               w_push;
   logic               w_pop;
   logic               w_done_hit;
   logic               w_wd_hit;
   logic [CYCLE_W-1:0] w_cycles_inc;
   sched_desc_t        w_push_desc;
   sched_desc_t        w_head;

   always_comb begin
      w_push_desc            = '0;
      w_push_desc.id         = DESC_ID_W'(job_id);
      w_push_desc.src        = DESC_ADDR_W'(job_src_addr);
      w_push_desc.des        = DESC_ADDR_W'(job_des_addr);
      w_push_desc.comp_len   = job_comp_len;
      w_push_desc.decomp_len = job_decomp_len;
   end

   assign job_ready = r_ready_en && !w_full;
   assign w_push    = job_valid && job_ready;

   sched_desc_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (w_push),
      .push_data (w_push_desc),
      .pop       (w_pop),
      .head      (w_head),
      .full      (w_full),
      .empty     (w_empty),
      .count     (queue_count)
   );

   // Done counts only once the engine has been seen low, masking a stale level.
   assign w_done_hit   = r_armed && eng_done;
   assign w_cycles_inc = sat_inc(r_cycles);

`ifdef DEC_SCHED_TIMEOUT_EN
   assign w_wd_hit = (w_cycles_inc >= TIMEOUT_CYCLES);
`else
   assign w_wd_hit = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      case (r_state)
         IDLE: begin
            if (!w_empty && eng_idle) begin
               w_state_nxt = LAUNCH;
            end
         end
         LAUNCH: begin
            w_pop       = 1'b1;
            w_state_nxt = RUN;
         end
         RUN: begin
            if (w_done_hit || w_wd_hit) begin
               w_state_nxt = REPORT;
            end
         end
         REPORT: begin
            if (cpl_ready) begin
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_ready_en   <= 1'b0;
         r_start      <= 1'b0;
         r_armed      <= 1'b0;
         r_timeout    <= 1'b0;
         r_id         <= '0;
         r_cycles     <= '0;
         r_eng_src    <= '0;
         r_eng_des    <= '0;
         r_eng_comp   <= '0;
         r_eng_decomp <= '0;
      end else begin
         r_ready_en <= 1'b1;
         r_start    <= (r_state == LAUNCH);
         case (r_state)
            LAUNCH: begin
               r_eng_src    <= w_head.src[ADDR_W-1:0];
               r_eng_des    <= w_head.des[ADDR_W-1:0];
               r_eng_comp   <= w_head.comp_len;
               r_eng_decomp <= w_head.decomp_len;
               r_id         <= w_head.id[ID_W-1:0];
               r_cycles     <= '0;
               r_armed      <= 1'b0;
               r_timeout    <= 1'b0;
            end
            RUN: begin
               r_cycles <= w_cycles_inc;
               if (!eng_done) begin
                  r_armed <= 1'b1;
               end
               if (!w_done_hit && w_wd_hit) begin
                  r_timeout <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign eng_start      = r_start;
   assign eng_src_addr   = r_eng_src;
   assign eng_des_addr   = r_eng_des;
   assign eng_comp_len   = r_eng_comp;
   assign eng_decomp_len = r_eng_decomp;
   assign cpl_valid      = (r_state == REPORT);
   assign cpl_id         = r_id;
   assign cpl_cycles     = r_cycles;
   assign cpl_timeout    = r_timeout;
   assign busy           = (r_state != IDLE) || !w_empty;

endmodule
`default_nettype wire

// File: tb/tb_dec_job_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_dec_job_scheduler
// Brief    : Directed self-checking bench for dec_job_scheduler.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dec_job_scheduler;

   logic        clk;
   logic        rst_n;
   logic        job_valid;
   logic        job_ready;
   logic [7:0]  job_id;
   logic [63:0] job_src_addr;
   logic [63:0] job_des_addr;
   logic [31:0] job_comp_len;
   logic [31:0] job_decomp_len;
   logic        eng_start;
   logic [63:0] eng_src_addr;
   logic [63:0] eng_des_addr;
   logic [31:0] eng_comp_len;
   logic [31:0] eng_decomp_len;
   logic        eng_idle;
   logic        eng_done;
   logic        cpl_valid;
   logic        cpl_ready;
   logic [7:0]  cpl_id;
   logic [31:0] cpl_cycles;
   logic        cpl_timeout;
   logic        busy;
   logic [2:0]  queue_count;

   int total;
   int bad;

   dec_job_scheduler #(
      .ADDR_W         (64),
      .ID_W           (8),
      .DEPTH          (4),
      .TIMEOUT_CYCLES (32'd1000)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .job_valid      (job_valid),
      .job_ready      (job_ready),
      .job_id         (job_id),
      .job_src_addr   (job_src_addr),
      .job_des_addr   (job_des_addr),
      .job_comp_len   (job_comp_len),
      .job_decomp_len (job_decomp_len),
      .eng_start      (eng_start),
      .eng_src_addr   (eng_src_addr),
      .eng_des_addr   (eng_des_addr),
      .eng_comp_len   (eng_comp_len),
      .eng_decomp_len (eng_decomp_len),
      .eng_idle       (eng_idle),
      .eng_done       (eng_done),
      .cpl_valid      (cpl_valid),
      .cpl_ready      (cpl_ready),
      .cpl_id         (cpl_id),
      .cpl_cycles     (cpl_cycles),
      .cpl_timeout    (cpl_timeout),
      .busy           (busy),
      .queue_count    (queue_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL global_timeout: simulation still running at %0t, want finished", $time);
      $fatal(1, "bench did not terminate");
   end

   function automatic logic [63:0] src_of(input logic [7:0] id);
      return {32'hA5A5_0000, 24'h0, id};
   endfunction

   function automatic logic [63:0] des_of(input logic [7:0] id);
      return {32'h5A5A_0000, 16'h0, id, 8'h00};
   endfunction

   // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic set_job(input logic [7:0] id, input logic [63:0] src, input logic [63:0] des,
                          input logic [31:0] cl, input logic [31:0] dl);
      job_valid      = 1'b1;
      job_id         = id;
      job_src_addr   = src;
      job_des_addr   = des;
      job_comp_len   = cl;
      job_decomp_len = dl;
   endtask

   task automatic set_std(input logic [7:0] id);
      set_job(id, src_of(id), des_of(id), {24'h0, id} << 4, {24'h0, id} << 6);
   endtask

   task automatic push_std(input logic [7:0] id);
      set_std(id);
      tick(1);
      job_valid = 1'b0;
   endtask

   task automatic wait_start(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         if (eng_start === 1'b1) ok = 1'b1;
         else tick(1);
      end
   endtask

   task automatic wait_cpl(input int limit, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < limit && !ok; i++) begin
         if (cpl_valid === 1'b1) ok = 1'b1;
         else tick(1);
      end
   endtask

   // Called in the start cycle: done is seen low there and high in RUN cycle done_at.
   task automatic finish_job(input int done_at);
      eng_done = 1'b0;
      tick(done_at - 1);
      eng_done = 1'b1;
   endtask

   task automatic handshake();
      cpl_ready = 1'b1;
      tick(1);
      cpl_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick(3);
      total++; if (job_ready !== 1'b0) begin bad++; $display("FAIL rst_ready: got %b want 0", job_ready); end
      total++; if ({eng_start, cpl_valid, busy, cpl_timeout} !== 4'b0000) begin bad++;
         $display("FAIL rst_flags: start/cpl_valid/busy/timeout got %b want 0000", {eng_start, cpl_valid, busy, cpl_timeout}); end
      total++; if (queue_count !== 3'd0) begin bad++; $display("FAIL rst_count: got %0d want 0", queue_count); end
      total++; if ({eng_src_addr, eng_des_addr, eng_comp_len, eng_decomp_len, cpl_id, cpl_cycles} !== '0) begin bad++;
         $display("FAIL rst_regs: eng_src=%h cpl_cycles=%0d want 0", eng_src_addr, cpl_cycles); end
      rst_n = 1'b1;
      total++; if (job_ready !== 1'b0) begin bad++; $display("FAIL rel_ready0: got %b want 0", job_ready); end
      tick(1);
      total++; if (job_ready !== 1'b1) begin bad++; $display("FAIL rel_ready1: got %b want 1", job_ready); end
   endtask

   task automatic test_single_job();
      eng_idle = 1'b1;
      eng_done = 1'b0;
      set_job(8'h05, 64'h0000_1234_5678_9A00, 64'h0000_0FED_CBA9_8700, 32'd100, 32'd400);
      tick(1);
      job_valid = 1'b0;
      total++; if (eng_start !== 1'b0) begin bad++; $display("FAIL single_early1: start got %b want 0", eng_start); end
      tick(1);
      total++; if (eng_start !== 1'b0) begin bad++; $display("FAIL single_early2: start got %b want 0", eng_start); end
      tick(1);
      total++; if (eng_start !== 1'b1) begin bad++; $display("FAIL single_latency: start got %b want 1", eng_start); end
      total++; if ({eng_src_addr, eng_des_addr, eng_comp_len, eng_decomp_len} !==
                   {64'h0000_1234_5678_9A00, 64'h0000_0FED_CBA9_8700, 32'd100, 32'd400}) begin bad++;
         $display("FAIL single_eng: src=%h des=%h clen=%0d dlen=%0d want 123456789a00/fedcba98700/100/400",
                  eng_src_addr, eng_des_addr, eng_comp_len, eng_decomp_len); end
      eng_idle = 1'b0;
      tick(1);
      total++; if (eng_start !== 1'b0) begin bad++; $display("FAIL single_pulse: start got %b want 0", eng_start); end
      tick(48);
      eng_done = 1'b1;
      tick(1);
      total++; if (cpl_valid !== 1'b1 || cpl_id !== 8'h05 || cpl_cycles !== 32'd50 || cpl_timeout !== 1'b0) begin bad++;
         $display("FAIL single_cpl: valid=%b id=%h cycles=%0d to=%b want 1/05/50/0", cpl_valid, cpl_id, cpl_cycles, cpl_timeout); end
      eng_idle = 1'b1;
      handshake();
      total++; if (cpl_valid !== 1'b0 || busy !== 1'b0) begin bad++;
         $display("FAIL single_after: valid=%b busy=%b want 0/0", cpl_valid, busy); end
   endtask

   task automatic test_stale_done();
      // eng_done is still high from the previous job.
      push_std(8'h06);
      tick(2);
      total++; if (eng_start !== 1'b1) begin bad++; $display("FAIL stale_start: got %b want 1", eng_start); end
      tick(3);
      total++; if (cpl_valid !== 1'b0) begin bad++; $display("FAIL stale_masked: cpl_valid got %b want 0", cpl_valid); end
      eng_done = 1'b0;
      tick(20);
      total++; if (cpl_valid !== 1'b0) begin bad++; $display("FAIL stale_wait: cpl_valid got %b want 0", cpl_valid); end
      eng_done = 1'b1;
      tick(1);
      total++; if (cpl_valid !== 1'b1 || cpl_id !== 8'h06 || cpl_cycles !== 32'd24) begin bad++;
         $display("FAIL stale_cpl: valid=%b id=%h cycles=%0d want 1/06/24", cpl_valid, cpl_id, cpl_cycles); end
      handshake();
   endtask

   task automatic test_fill_order();
      bit ok;
      eng_idle = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         total++; if (job_ready !== 1'b1) begin bad++; $display("FAIL fill_ready%0d: got %b want 1", i, job_ready); end
         push_std(8'(i));
      end
      total++; if (job_ready !== 1'b0 || queue_count !== 3'd4) begin bad++;
         $display("FAIL fill_full: ready=%b count=%0d want 0/4", job_ready, queue_count); end
      set_std(8'd5);
      tick(3);
      total++; if (job_ready !== 1'b0 || queue_count !== 3'd4) begin bad++;
         $display("FAIL fill_hold: ready=%b count=%0d want 0/4", job_ready, queue_count); end
      eng_idle = 1'b1;
      tick(1);
      total++; if (queue_count !== 3'd4) begin bad++; $display("FAIL fill_launch: count=%0d want 4", queue_count); end
      tick(1);
      eng_done = 1'b0;
      total++; if (eng_start !== 1'b1 || queue_count !== 3'd3 || job_ready !== 1'b1) begin bad++;
         $display("FAIL fill_pop: start=%b count=%0d ready=%b want 1/3/1", eng_start, queue_count, job_ready); end
      tick(1);
      job_valid = 1'b0;
      total++; if (queue_count !== 3'd4) begin bad++; $display("FAIL fill_refill: count=%0d want 4", queue_count); end
      eng_done = 1'b1;
      wait_cpl(10, ok);
      total++; if (!ok || cpl_id !== 8'd1 || cpl_cycles !== 32'd2) begin bad++;
         $display("FAIL order_1: seen=%b id=%0d cycles=%0d want 1/1/2", ok, cpl_id, cpl_cycles); end
      handshake();
      for (int k = 2; k <= 6; k++) begin
         wait_start(ok);
         total++; if (!ok) begin bad++; $display("FAIL order_start%0d: start seen=%b want 1", k, ok); end
         finish_job(3);
         wait_cpl(10, ok);
         total++; if (!ok || cpl_id !== 8'(k)) begin bad++;
            $display("FAIL order_%0d: seen=%b id=%0d want 1/%0d", k, ok, cpl_id, k); end
         handshake();
         if (k == 2) begin
            tick(1);
            total++; if (queue_count !== 3'd3 || job_ready !== 1'b1) begin bad++;
               $display("FAIL simul_pre: count=%0d ready=%b want 3/1", queue_count, job_ready); end
            set_std(8'd6);
            tick(1);
            job_valid = 1'b0;
            total++; if (queue_count !== 3'd3 || eng_start !== 1'b1) begin bad++;
               $display("FAIL simul_post: count=%0d start=%b want 3/1", queue_count, eng_start); end
         end
      end
   endtask

   task automatic test_backpressure();
      bit ok;
      eng_idle = 1'b0;
      push_std(8'h21);
      push_std(8'h22);
      push_std(8'h23);
      eng_idle = 1'b1;
      wait_start(ok);
      total++; if (!ok) begin bad++; $display("FAIL bp_start: seen=%b want 1", ok); end
      finish_job(5);
      wait_cpl(10, ok);
      total++; if (!ok) begin bad++; $display("FAIL bp_cpl: seen=%b want 1", ok); end
      for (int i = 0; i < 10; i++) begin
         total++; if (cpl_valid !== 1'b1 || cpl_id !== 8'h21 || cpl_cycles !== 32'd5 || eng_start !== 1'b0 || queue_count !== 3'd2) begin bad++;
            $display("FAIL bp_hold%0d: valid=%b id=%h cycles=%0d start=%b count=%0d want 1/21/5/0/2",
                     i, cpl_valid, cpl_id, cpl_cycles, eng_start, queue_count); end
         tick(1);
      end
      handshake();
      total++; if (eng_start !== 1'b0) begin bad++; $display("FAIL bp_gap1: start=%b want 0", eng_start); end
      tick(1);
      total++; if (eng_start !== 1'b0) begin bad++; $display("FAIL bp_gap2: start=%b want 0", eng_start); end
      tick(1);
      total++; if (eng_start !== 1'b1 || eng_src_addr !== src_of(8'h22)) begin bad++;
         $display("FAIL bp_next: start=%b src=%h want 1/%h", eng_start, eng_src_addr, src_of(8'h22)); end
      finish_job(2);
      wait_cpl(10, ok);
      total++; if (!ok || cpl_id !== 8'h22 || cpl_cycles !== 32'd2) begin bad++;
         $display("FAIL bp_min: seen=%b id=%h cycles=%0d want 1/22/2", ok, cpl_id, cpl_cycles); end
      handshake();
      wait_start(ok);
      finish_job(4);
      wait_cpl(10, ok);
      total++; if (!ok || cpl_id !== 8'h23 || cpl_cycles !== 32'd4) begin bad++;
         $display("FAIL bp_last: seen=%b id=%h cycles=%0d want 1/23/4", ok, cpl_id, cpl_cycles); end
      handshake();
   endtask

`ifdef DEC_SCHED_TIMEOUT_EN
   task automatic test_timeout();
      bit ok;
      eng_idle = 1'b1;
      push_std(8'h41);
      wait_start(ok);
      eng_done = 1'b0;
      wait_cpl(1100, ok);
      total++; if (!ok || cpl_timeout !== 1'b1 || cpl_cycles !== 32'd1000 || cpl_id !== 8'h41) begin bad++;
         $display("FAIL wd_cpl: seen=%b to=%b cycles=%0d id=%h want 1/1/1000/41", ok, cpl_timeout, cpl_cycles, cpl_id); end
      handshake();
   endtask
`endif

   task automatic test_reset_mid_job();
      bit ok;
      eng_idle = 1'b1;
      push_std(8'h31);
      wait_start(ok);
      eng_done = 1'b0;
      push_std(8'h32);
      push_std(8'h33);
      tick(3);
      total++; if (!ok || busy !== 1'b1 || queue_count !== 3'd2) begin bad++;
         $display("FAIL mid_pre: start=%b busy=%b count=%0d want 1/1/2", ok, busy, queue_count); end
      rst_n = 1'b0;
      tick(2);
      total++; if (cpl_valid !== 1'b0 || queue_count !== 3'd0 || busy !== 1'b0 || job_ready !== 1'b0 || eng_start !== 1'b0) begin bad++;
         $display("FAIL mid_rst: valid=%b count=%0d busy=%b ready=%b start=%b want 0/0/0/0/0",
                  cpl_valid, queue_count, busy, job_ready, eng_start); end
      total++; if (eng_src_addr !== 64'h0 || cpl_id !== 8'h0 || cpl_cycles !== 32'd0) begin bad++;
         $display("FAIL mid_regs: src=%h id=%h cycles=%0d want 0/0/0", eng_src_addr, cpl_id, cpl_cycles); end
      rst_n = 1'b1;
      tick(1);
      total++; if (job_ready !== 1'b1 || queue_count !== 3'd0 || busy !== 1'b0) begin bad++;
         $display("FAIL mid_after: ready=%b count=%0d busy=%b want 1/0/0", job_ready, queue_count, busy); end
      for (int i = 0; i < 5; i++) begin
         total++; if (eng_start !== 1'b0) begin bad++; $display("FAIL mid_nostart%0d: start=%b want 0", i, eng_start); end
         tick(1);
      end
   endtask

   initial begin
      total          = 0;
      bad            = 0;
      rst_n          = 1'b0;
      job_valid      = 1'b0;
      job_id         = '0;
      job_src_addr   = '0;
      job_des_addr   = '0;
      job_comp_len   = '0;
      job_decomp_len = '0;
      eng_idle       = 1'b1;
      eng_done       = 1'b0;
      cpl_ready      = 1'b0;

      test_reset();
      test_single_job();
      test_stale_done();
      test_fill_order();
      test_backpressure();
`ifdef DEC_SCHED_TIMEOUT_EN
      test_timeout();
`endif
      test_reset_mid_job();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
